pc_sequencer: RTL and testbench

- Consumer end of the main control unit's decode outputs. Takes fetch_en, ir_type, return_en, iterations_en, zero plus opcode/func, and produces the next instruction address.
- Owns the PC register, the return register (RR) for CALL/RET, and the FOR-loop iteration counter.
- Sits between the control unit/ALU flag and the instruction memory address port.

---
 rtl/cpu_isa_pkg.sv | 35 +++
 rtl/loop_iter_ctrl.sv | 68 ++++++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA encodings for the control path: opcodes, J-type func codes,
// ir_type values and the FOR-loop state enum.
package cpu_isa_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_JTYPE = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNE   = 4'b0111;
  localparam logic [3:0] OP_FOR   = 4'b1000;

  // Every opcode from here upward is unassigned.
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'b1001;

  localparam logic [2:0] JF_JMP  = 3'b000;
  localparam logic [2:0] JF_CALL = 3'b001;
  localparam logic [2:0] JF_RET  = 3'b010;

  localparam logic [1:0] IR_R = 2'd0;
  localparam logic [1:0] IR_I = 2'd1;
  localparam logic [1:0] IR_J = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOOP = 1'b1
  } loop_state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= OP_FIRST_ILLEGAL;
  endfunction

endpackage

// File: rtl/loop_iter_ctrl.sv
// FOR-loop controller: IDLE/LOOP FSM plus the remaining-iteration counter.
// o_take_loop tells the sequencer to branch back to the loop target.
module loop_iter_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_for_en,
  input  logic [ITER_W-1:0] i_loop_count,
  output logic              o_take_loop,
  output logic [ITER_W-1:0] o_iter_count,
  output loop_state_e       o_state
);

  loop_state_e       r_state;
  loop_state_e       w_state_next;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] w_iter_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_next;
      r_iter  <= w_iter_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_iter_next  = r_iter;
    o_take_loop  = 1'b0;
    if (i_for_en) begin
      case (r_state)
        ST_IDLE: begin
          // A count of 0 or 1 means the body already ran its only pass.
          if (i_loop_count > ITER_W'(1)) begin
            w_iter_next  = i_loop_count - ITER_W'(1);
            w_state_next = ST_LOOP;
            o_take_loop  = 1'b1;
          end else begin
            w_iter_next = '0;
          end
        end
        ST_LOOP: begin
          if (r_iter > ITER_W'(1)) begin
            w_iter_next = r_iter - ITER_W'(1);
            o_take_loop = 1'b1;
          end else begin
            w_iter_next  = '0;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_iter_next  = '0;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign o_iter_count = r_iter;
  assign o_state      = r_state;

endmodule

// File: rtl/pc_sequencer.sv
// Next-instruction-address unit: PC, return register and FOR-loop counter.
// Define PC_SEQ_RAS_EN to replace the single return register with a return stack.
module pc_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int ITER_W = 16
`ifdef PC_SEQ_RAS_EN
  ,
  parameter int RAS_DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              fetch_en,
  input  logic [1:0]        ir_type,
  input  logic [3:0]        opcode,
  input  logic [2:0]        func,
  input  logic              zero,
  input  logic              return_en,
  input  logic              iterations_en,
  input  logic [PC_W-1:0]   offset,
  input  logic [PC_W-1:0]   loop_target,
  input  logic [ITER_W-1:0] loop_count,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   rr,
  output logic [ITER_W-1:0] iter_count,
  output logic              loop_active,
  output logic              illegal_op
);

  logic [PC_W-1:0] r_pc;
  logic            r_illegal;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic            w_illegal;
  logic            w_adv;
  logic            w_take_loop;
  logic            w_rr_we;
  logic            w_ret;
  logic            w_unused;
  loop_state_e     w_loop_state;

  assign w_illegal = is_illegal(opcode);
  // An illegal opcode bypasses the normal update path entirely.
  assign w_adv     = !stall && fetch_en && !w_illegal;
  assign w_pc_inc  = r_pc + PC_W'(1);

  loop_iter_ctrl #(
    .ITER_W(ITER_W)
  ) u_loop (
    .clk         (clk),
    .reset       (reset),
    .i_for_en    (w_adv && iterations_en),
    .i_loop_count(loop_count),
    .o_take_loop (w_take_loop),
    .o_iter_count(iter_count),
    .o_state     (w_loop_state)
  );

  always_comb begin
    w_pc_next = w_pc_inc;
    w_rr_we   = 1'b0;
    w_ret     = 1'b0;
    if (iterations_en) begin
      w_pc_next = w_take_loop ? loop_target : w_pc_inc;
    end else begin
      case (opcode)
        OP_JTYPE: begin
          case (func)
            JF_JMP:  w_pc_next = r_pc + offset;
            JF_CALL: begin
              w_pc_next = r_pc + offset;
              w_rr_we   = return_en;
            end
            JF_RET: begin
              w_pc_next = rr;
              w_ret     = 1'b1;
            end
            default: w_pc_next = w_pc_inc;
          endcase
        end
        OP_BEQ:  w_pc_next = zero ? (w_pc_inc + offset) : w_pc_inc;
        OP_BNE:  w_pc_next = zero ? w_pc_inc : (w_pc_inc + offset);
        default: w_pc_next = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (stall) begin
      r_illegal <= 1'b0;
    end else if (w_illegal) begin
      r_pc      <= w_pc_inc;
      r_illegal <= 1'b1;
    end else begin
      r_illegal <= 1'b0;
      if (fetch_en) begin
        r_pc <= w_pc_next;
      end
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Entry 0 is the top; zero-fill on pop makes an empty stack read back 0,
  // and shifting on push drops the oldest entry off the bottom.
  logic [PC_W-1:0] r_ras [RAS_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_adv && w_rr_we) begin
      r_ras[0] <= w_pc_inc;
      for (int i = 1; i < RAS_DEPTH; i++) begin
        r_ras[i] <= r_ras[i-1];
      end
    end else if (w_adv && w_ret) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++) begin
        r_ras[i] <= r_ras[i+1];
      end
      r_ras[RAS_DEPTH-1] <= '0;
    end
  end

  assign rr       = r_ras[0];
  assign w_unused = ^ir_type;
`else
  logic [PC_W-1:0] r_rr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (w_adv && w_rr_we) begin
      r_rr <= w_pc_inc;
    end
  end

  assign rr       = r_rr;
  assign w_unused = ^{ir_type, w_ret};
`endif

  assign pc          = r_pc;
  assign illegal_op  = r_illegal;
  assign loop_active = (w_loop_state == ST_LOOP);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; scoreboard entries are
// {loop_active, iter_count, pc}. Define PC_SEQ_RAS_EN to exercise the return stack.
module tb_pc_sequencer;
  import cpu_isa_pkg::*;

  localparam int PC_W   = 16;
  localparam int ITER_W = 16;
  localparam int W      = 1 + ITER_W + PC_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              fetch_en;
  logic [1:0]        ir_type;
  logic [3:0]        opcode;
  logic [2:0]        func;
  logic              zero;
  logic              return_en;
  logic              iterations_en;
  logic [PC_W-1:0]   offset;
  logic [PC_W-1:0]   loop_target;
  logic [ITER_W-1:0] loop_count;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   rr;
  logic [ITER_W-1:0] iter_count;
  logic              loop_active;
  logic              illegal_op;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;
  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .PC_W  (PC_W),
    .ITER_W(ITER_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .fetch_en     (fetch_en),
    .ir_type      (ir_type),
    .opcode       (opcode),
    .func         (func),
    .zero         (zero),
    .return_en    (return_en),
    .iterations_en(iterations_en),
    .offset       (offset),
    .loop_target  (loop_target),
    .loop_count   (loop_count),
    .pc           (pc),
    .rr           (rr),
    .iter_count   (iter_count),
    .loop_active  (loop_active),
    .illegal_op   (illegal_op)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    stall         = 1'b0;
    fetch_en      = 1'b1;
    ir_type       = IR_R;
    opcode        = OP_RTYPE;
    func          = 3'b000;
    zero          = 1'b0;
    return_en     = 1'b0;
    iterations_en = 1'b0;
    offset        = '0;
    loop_target   = '0;
    loop_count    = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic jump_to(input logic [PC_W-1:0] addr);
    do_reset();
    ir_type = IR_J;
    opcode  = OP_JTYPE;
    func    = JF_JMP;
    offset  = addr;
    tick();
    set_idle();
  endtask

  task automatic drive_jfunc(input logic [2:0] f, input logic [PC_W-1:0] off, input logic ren);
    set_idle();
    ir_type   = IR_J;
    opcode    = OP_JTYPE;
    func      = f;
    offset    = off;
    return_en = ren;
  endtask

  task automatic drive_for(input logic [PC_W-1:0] tgt, input logic [ITER_W-1:0] cnt);
    set_idle();
    ir_type       = IR_I;
    opcode        = OP_FOR;
    iterations_en = 1'b1;
    loop_target   = tgt;
    loop_count    = cnt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    tick();
    total++;
    if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
    total++;
    if (rr !== 16'h0000) begin bad++; $display("FAIL reset_rr: got %h want 0000", rr); end
    total++;
    if (iter_count !== 16'h0000) begin bad++; $display("FAIL reset_iter: got %h want 0000", iter_count); end
    total++;
    if (loop_active !== 1'b0) begin bad++; $display("FAIL reset_loop_active: got %b want 0", loop_active); end
    total++;
    if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({1'b0, 16'h0000, 16'(i)});
      tick();
      obs   = {loop_active, iter_count, pc};
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rtype_step%0d: got %h want %h", i, obs, exp_v); end
    end
    total++;
    if (rr !== 16'h0000) begin bad++; $display("FAIL rtype_rr: got %h want 0000", rr); end
  endtask

  task automatic test_call_ret();
    jump_to(16'h0010);
    drive_jfunc(JF_CALL, 16'h0020, 1'b1);
    exp_q.push_back({1'b0, 16'h0000, 16'h0030});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL call_pc: got %h want %h", obs, exp_v); end
    total++;
    if (rr !== 16'h0011) begin bad++; $display("FAIL call_rr: got %h want 0011", rr); end

    drive_jfunc(JF_RET, 16'h0000, 1'b0);
    exp_q.push_back({1'b0, 16'h0000, 16'h0011});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ret_pc: got %h want %h", obs, exp_v); end
`ifdef PC_SEQ_RAS_EN
    total++;
    if (rr !== 16'h0000) begin bad++; $display("FAIL ret_rr: got %h want 0000", rr); end
`else
    total++;
    if (rr !== 16'h0011) begin bad++; $display("FAIL ret_rr: got %h want 0011", rr); end
`endif

    // CALL without return_en must not touch rr.
    drive_jfunc(JF_CALL, 16'h0005, 1'b0);
    exp_q.push_back({1'b0, 16'h0000, 16'h0016});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL call_noret_pc: got %h want %h", obs, exp_v); end
`ifdef PC_SEQ_RAS_EN
    total++;
    if (rr !== 16'h0000) begin bad++; $display("FAIL call_noret_rr: got %h want 0000", rr); end
`else
    total++;
    if (rr !== 16'h0011) begin bad++; $display("FAIL call_noret_rr: got %h want 0011", rr); end
`endif

    // JMP wrap-around and an unused J func.
    drive_jfunc(JF_JMP, 16'hFFEA, 1'b0);
    exp_q.push_back({1'b0, 16'h0000, 16'h0000});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL jmp_wrap: got %h want %h", obs, exp_v); end
    drive_jfunc(3'b011, 16'h0040, 1'b1);
    exp_q.push_back({1'b0, 16'h0000, 16'h0001});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL jfunc3_pc: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_branch();
    logic [3:0]      ops [4];
    logic            zs  [4];
    logic [PC_W-1:0] pcs [4];
    ops = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1};
    pcs = '{16'h0005, 16'h0009, 16'h0005, 16'h0009};
    for (int i = 0; i < 4; i++) begin
      jump_to(16'h0008);
      ir_type = IR_I;
      opcode  = ops[i];
      zero    = zs[i];
      offset  = 16'hFFFC;
      exp_q.push_back({1'b0, 16'h0000, pcs[i]});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL branch_case%0d: got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_for_loop();
    // 1 = FOR at pc 6, 0 = body instruction; body sits at 4..5.
    logic            is_for [7];
    logic [W-1:0]    exps   [7];
    is_for = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exps   = '{{1'b1, 16'd2, 16'h0004}, {1'b1, 16'd2, 16'h0005}, {1'b1, 16'd2, 16'h0006},
               {1'b1, 16'd1, 16'h0004}, {1'b1, 16'd1, 16'h0005}, {1'b1, 16'd1, 16'h0006},
               {1'b0, 16'd0, 16'h0007}};
    jump_to(16'h0006);
    for (int i = 0; i < 7; i++) begin
      if (is_for[i]) drive_for(16'h0004, 16'd3);
      else set_idle();
      exp_q.push_back(exps[i]);
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL for3_step%0d: got %h want %h", i, obs, exp_v); end
    end
    for (int c = 0; c < 2; c++) begin
      jump_to(16'h0006);
      drive_for(16'h0004, 16'(c));
      exp_q.push_back({1'b0, 16'd0, 16'h0007});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL for_count%0d: got %h want %h", c, obs, exp_v); end
    end
  endtask

  task automatic test_reset_stall_mid_loop();
    jump_to(16'h0006);
    drive_for(16'h0004, 16'd6);
    exp_q.push_back({1'b1, 16'd5, 16'h0004});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL for6_enter: got %h want %h", obs, exp_v); end
    reset = 1'b1;
    exp_q.push_back({1'b0, 16'd0, 16'h0000});
    tick();
    reset = 1'b0;
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_mid_loop: got %h want %h", obs, exp_v); end

    jump_to(16'h0006);
    drive_for(16'h0004, 16'd3);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_for(16'h0004, 16'd3);
      stall = 1'b1;
      if (i == 1) begin
        iterations_en = 1'b0;
        opcode        = 4'b1010;
      end
      exp_q.push_back({1'b1, 16'd2, 16'h0004});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stall_cycle%0d: got %h want %h", i, obs, exp_v); end
      total++;
      if (illegal_op !== 1'b0) begin bad++; $display("FAIL stall_illegal%0d: got %b want 0", i, illegal_op); end
    end
    set_idle();
    exp_q.push_back({1'b1, 16'd2, 16'h0005});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL after_stall: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_illegal();
    logic [3:0]      ops  [4];
    logic            fens [4];
    logic [PC_W-1:0] pcs  [4];
    logic            ills [4];
    ops  = '{4'b1010, OP_RTYPE, 4'b1001, OP_FOR};
    fens = '{1'b0, 1'b1, 1'b1, 1'b1};
    pcs  = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    ills = '{1'b1, 1'b0, 1'b1, 1'b0};
    jump_to(16'h00FF);
    for (int i = 0; i < 4; i++) begin
      set_idle();
      opcode   = ops[i];
      fetch_en = fens[i];
      exp_q.push_back({1'b0, 16'd0, pcs[i]});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL illegal_pc%0d: got %h want %h", i, obs, exp_v); end
      total++;
      if (illegal_op !== ills[i]) begin bad++; $display("FAIL illegal_flag%0d: got %b want %b", i, illegal_op, ills[i]); end
    end
    // fetch_en low holds pc on a legal jump.
    drive_jfunc(JF_JMP, 16'h0055, 1'b0);
    fetch_en = 1'b0;
    exp_q.push_back({1'b0, 16'd0, 16'h0103});
    tick();
    obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fetch_hold: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] model_pc;
    logic            is_jmp;
    logic [3:0]      legal_ops [5];
    legal_ops = '{OP_RTYPE, OP_ANDI, OP_ADDI, OP_LW, OP_SW};
    do_reset();
    model_pc = '0;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      stall    = ($urandom_range(0, 3) == 0);
      fetch_en = ($urandom_range(0, 4) != 0);
      is_jmp   = ($urandom_range(0, 1) == 1);
      offset   = 16'($urandom_range(0, 65535));
      zero     = 1'($urandom_range(0, 1));
      if (is_jmp) begin
        ir_type = IR_J;
        opcode  = OP_JTYPE;
      end else begin
        opcode = legal_ops[$urandom_range(0, 4)];
      end
      if (!stall && fetch_en) model_pc = is_jmp ? (model_pc + offset) : (model_pc + 16'd1);
      exp_q.push_back({1'b0, 16'd0, model_pc});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL b2b_step%0d: got %h want %h", i, obs, exp_v); end
    end
  endtask

`ifdef PC_SEQ_RAS_EN
  task automatic test_ras();
    logic [PC_W-1:0] ret_pcs [5];
    ret_pcs = '{16'h0041, 16'h0031, 16'h0021, 16'h0011, 16'h0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_jfunc(JF_CALL, 16'h0010, 1'b1);
      exp_q.push_back({1'b0, 16'd0, 16'(16 * (i + 1))});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ras_call%0d: got %h want %h", i, obs, exp_v); end
      total++;
      if (rr !== 16'(16 * i + 1)) begin bad++; $display("FAIL ras_top%0d: got %h want %h", i, rr, 16'(16 * i + 1)); end
    end
    for (int i = 0; i < 5; i++) begin
      drive_jfunc(JF_RET, 16'h0000, 1'b0);
      exp_q.push_back({1'b0, 16'd0, ret_pcs[i]});
      tick();
      obs = {loop_active, iter_count, pc}; exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ras_ret%0d: got %h want %h", i, obs, exp_v); end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_rtype();
    test_call_ret();
    test_branch();
    test_for_loop();
    test_reset_stall_mid_loop();
    test_illegal();
    test_back_to_back();
`ifdef PC_SEQ_RAS_EN
    test_ras();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
